// File: rtl/fir_out_pkg.sv
// Shared constants and FSM encoding for the FIR output stream buffer.
package fir_out_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_LEN_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Register-array synchronous FIFO; occupancy tracked by a level counter.
// Latency: a word pushed in cycle N appears on pop_data in cycle N+1, no bypass.
// Backpressure: push while full and pop while empty are ignored; caller gates on full/empty.
module fir_sync_fifo #(
    parameter int DEPTH       = 8,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     push,
    input  logic [pDATA_WIDTH-1:0]   push_data,
    input  logic                     pop,
    output logic [pDATA_WIDTH-1:0]   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [pDATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fir_stream_out_buf.sv
// FIR output buffer: FIFO-decoupled stream, regenerated m_tlast from frame length, done pulse.
// Latency: one cycle s_* to m_*; s_tready depends on registered state only. Optional FIR_OUT_STALL_CNT_EN.
// Backpressure: sink stalls fill the FIFO; s_tready drops when full or once len beats are accepted.
module fir_stream_out_buf
    import fir_out_pkg::*;
#(
    parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   data_length,
    output logic                   busy,
    output logic                   done,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            stall_cnt
);

    state_t               state;
    state_t               state_nxt;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] in_cnt;
    logic [LEN_WIDTH-1:0] out_cnt;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 at_last;
    logic                 start_acc;

    assign start_acc = start && (state == IDLE);
    assign s_tready  = (state == STREAM) && !full && (in_cnt < len);
    assign push      = s_tvalid && s_tready;
    assign m_tvalid  = !empty;
    assign pop       = m_tvalid && m_tready;
    // len-1 is only meaningful for a non-empty frame.
    assign at_last   = (len != '0) && (out_cnt == len - LEN_WIDTH'(1));
    assign m_tlast   = m_tvalid && at_last;
    assign busy      = (state == STREAM);
    assign done      = (state == DONE);

    fir_sync_fifo #(
        .DEPTH       (DEPTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_fifo (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .push      (push),
        .push_data (s_tdata),
        .pop       (pop),
        .pop_data  (m_tdata),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (data_length == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (pop && at_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            len     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start_acc) begin
            len     <= data_length;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) in_cnt  <= in_cnt + LEN_WIDTH'(1);
            if (pop)  out_cnt <= out_cnt + LEN_WIDTH'(1);
        end
    end

`ifdef FIR_OUT_STALL_CNT_EN
    always_ff @(posedge axis_clk) begin
        if (axis_rst || start_acc) begin
            stall_cnt <= '0;
        end else if (m_tvalid && !m_tready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_stream_out_buf.sv
// Randomized bench for fir_stream_out_buf with a queue-based frame model checked every cycle.
module tb_fir_stream_out_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 10;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          start;
    logic [LW-1:0] data_length;
    logic          busy, done;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic [3:0]    level;
    logic [31:0]   stall_cnt;

    fir_stream_out_buf #(.pDATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .start       (start),
        .data_length (data_length),
        .busy        (busy),
        .done        (done),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .level       (level),
        .stall_cnt   (stall_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int vectors    = 0;
    int miscompare = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompare++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Stimulus state shared with the source and sink processes
    logic [DW-1:0] src_q[$];
    int vprob = 100;
    int rprob = 100;
    bit chk_en = 0;

    // Observations
    logic [DW-1:0] got_q[$];
    int tlast_cnt = 0;
    logic [DW-1:0] tlast_val = '0;
    int done_cnt = 0;

    // Frame model: active flag, pending done, length, beat counts, buffered words
    bit            m_act = 0;
    bit            m_dpend = 0;
    int            m_len = 0;
    int            m_in = 0;
    int            m_out = 0;
    logic [DW-1:0] m_q[$];
    logic [31:0]   m_stall = '0;

    task automatic cyc();
        @(posedge axis_clk);
        #2;
    endtask

    // AXI source: holds a word until accepted
    initial begin
        bit acc;
        bit hold;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        forever begin
            @(negedge axis_clk);
            acc = s_tvalid && s_tready;
            @(posedge axis_clk);
            #1;
            if (acc && src_q.size() > 0) void'(src_q.pop_front());
            hold = s_tvalid && !acc;
            if (src_q.size() > 0) begin
                s_tvalid = hold || ($urandom_range(99) < vprob);
                s_tdata  = src_q[0];
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge axis_clk);
            #1;
            m_tready = ($urandom_range(99) < rprob);
        end
    end

    // Per-cycle compare against the model, then advance the model by one clock
    initial begin
        bit e_vld, e_push, e_pop, start_ok;
        forever begin
            @(negedge axis_clk);
            if (chk_en) begin
                e_vld = (m_q.size() > 0);
                chk("s_tready", s_tready, m_act && (m_q.size() < DEPTH) && (m_in < m_len));
                chk("m_tvalid", m_tvalid, e_vld);
                if (e_vld) chk("m_tdata", m_tdata, m_q[0]);
                chk("m_tlast", m_tlast, e_vld && (m_len != 0) && (m_out == m_len - 1));
                chk("level", level, m_q.size());
                chk("busy", busy, m_act);
                chk("done", done, m_dpend);
`ifdef FIR_OUT_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, m_stall);
`else
                chk("stall_cnt", stall_cnt, 0);
`endif
                if (m_tvalid && m_tready) begin
                    got_q.push_back(m_tdata);
                    if (m_tlast) begin
                        tlast_cnt++;
                        tlast_val = m_tdata;
                    end
                end
                if (done) done_cnt++;

                if (axis_rst) begin
                    m_act = 0; m_dpend = 0; m_len = 0; m_in = 0; m_out = 0;
                    m_q.delete();
                    m_stall = '0;
                end else begin
                    e_push   = m_act && (m_q.size() < DEPTH) && (m_in < m_len) && s_tvalid;
                    e_pop    = e_vld && m_tready;
                    start_ok = !m_act && !m_dpend && start;
                    if (start_ok) m_stall = '0;
                    else if (e_vld && !m_tready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                    if (m_dpend) begin
                        m_dpend = 0;
                    end else if (m_act && e_pop && (m_out == m_len - 1)) begin
                        m_act = 0;
                        m_dpend = 1;
                    end else if (start_ok) begin
                        m_len = int'(data_length);
                        m_in = 0;
                        m_out = 0;
                        if (m_len == 0) m_dpend = 1;
                        else m_act = 1;
                    end
                    if (e_pop) begin
                        void'(m_q.pop_front());
                        m_out++;
                    end
                    if (e_push) begin
                        m_q.push_back(s_tdata);
                        m_in++;
                    end
                end
            end
        end
    end

    task automatic clear_obs();
        got_q.delete();
        tlast_cnt = 0;
        tlast_val = '0;
        done_cnt  = 0;
    endtask

    task automatic start_frame(input int len);
        start = 1'b1;
        data_length = LW'(len);
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            cyc();
            n++;
        end
        chk("done_seen", done_cnt != d0, 1);
    endtask

    task automatic load_seq(input int first, input int count);
        src_q.delete();
        for (int i = 0; i < count; i++) src_q.push_back(DW'(first + i));
    endtask

    initial begin
        int n;
        int len;
        axis_rst = 1'b1;
        start = 1'b0;
        data_length = '0;
        repeat (3) cyc();
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_level", level, 0);
        chk("rst_sready", s_tready, 0);
        axis_rst = 1'b0;
        cyc();

        // 1: eleven beats with an always-ready sink
        clear_obs(); vprob = 100; rprob = 100;
        load_seq(1, 11);
        start_frame(11);
        wait_done(200);
        chk("t1_count", got_q.size(), 11);
        for (int i = 0; i < 11; i++) chk("t1_data", got_q[i], i + 1);
        chk("t1_tlast_cnt", tlast_cnt, 1);
        chk("t1_tlast_val", tlast_val, 11);
        chk("t1_busy", busy, 0);
        cyc(); cyc();
        chk("t1_done_cnt", done_cnt, 1);

        // 2: sink stalled for 30 cycles, FIFO fills to DEPTH
        clear_obs(); vprob = 100; rprob = 0;
        load_seq(1, 20);
        start_frame(20);
        repeat (30) cyc();
        chk("t2_level", level, 8);
        chk("t2_sready", s_tready, 0);
        chk("t2_none_out", got_q.size(), 0);
        rprob = 100;
        wait_done(300);
        chk("t2_count", got_q.size(), 20);
        for (int i = 0; i < 20; i++) chk("t2_data", got_q[i], i + 1);
        chk("t2_tlast_cnt", tlast_cnt, 1);

        // 3: source over-offers; extra beats stay with the source
        cyc();
        clear_obs(); vprob = 100; rprob = 100;
        load_seq(100, 6);
        start_frame(4);
        wait_done(200);
        chk("t3_count", got_q.size(), 4);
        chk("t3_left", src_q.size(), 2);
        chk("t3_tlast_val", tlast_val, 103);
        chk("t3_sready", s_tready, 0);
        src_q.delete();
        cyc(); cyc();

        // 4: zero-length frame goes straight to done
        clear_obs();
        start_frame(0);
        chk("t4_done_hi", done, 1);
        chk("t4_sready", s_tready, 0);
        cyc();
        chk("t4_done_lo", done, 0);
        chk("t4_mvalid", m_tvalid, 0);

        // 5: reset mid-frame with five words buffered
        cyc();
        clear_obs(); vprob = 100; rprob = 0;
        load_seq(50, 20);
        start_frame(20);
        n = 0;
        while (level != 4'd5 && n < 50) begin
            cyc();
            n++;
        end
        chk("t5_level5", level, 5);
        axis_rst = 1'b1;
        src_q.delete();
        cyc();
        chk("t5_mvalid", m_tvalid, 0);
        chk("t5_level", level, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        axis_rst = 1'b0;
        repeat (5) cyc();
        chk("t5_no_done", done_cnt, 0);

        // 6: seven stalled cycles with a word waiting
        clear_obs(); vprob = 100; rprob = 0;
        load_seq(7, 3);
        start_frame(3);
        n = 0;
        while (!m_tvalid && n < 20) begin
            cyc();
            n++;
        end
        chk("t6_mvalid", m_tvalid, 1);
        repeat (7) cyc();
`ifdef FIR_OUT_STALL_CNT_EN
        chk("t6_stall", stall_cnt, 7);
`else
        chk("t6_stall", stall_cnt, 0);
`endif
        rprob = 100;
        wait_done(100);
        cyc();

        // Random frames
        for (int f = 0; f < 12; f++) begin
            clear_obs();
            len = int'($urandom_range(1, 40));
            src_q.delete();
            for (int i = 0; i < len + int'($urandom_range(0, 3)); i++) src_q.push_back($urandom);
            vprob = int'($urandom_range(30, 100));
            rprob = int'($urandom_range(20, 100));
            start_frame(len);
            wait_done(2000);
            chk("rnd_count", got_q.size(), len);
            chk("rnd_tlast_cnt", tlast_cnt, 1);
            src_q.delete();
            cyc(); cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
        $finish;
    end

endmodule
